// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a registered output queue.
//   Parameters: CLK_DIV    - clk cycles per bit (even, >= 4)
//               FIFO_DEPTH - receive FIFO entries (power of two, >= 2),
//                            only used when UART_RX_FIFO_EN is defined
//   Macro:      UART_RX_FIFO_EN - when defined the output queue is a
//               FIFO_DEPTH-entry FIFO, otherwise a single holding register.
//   Ports:      clk       - clock, all state updates on its rising edge
//               rst       - synchronous active-high reset
//               rx        - asynchronous serial line, idle high
//               data      - byte at the head of the output queue
//               valid     - data holds a byte
//               ready     - consumer accepts data when valid && ready
//               frame_err - one-cycle pulse when a stop bit samples low
//               overrun   - one-cycle pulse when a good byte is dropped
`timescale 1ns/1ps

module uart_rx #(
  parameter int unsigned CLK_DIV    = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int unsigned CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLK_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CLK_DIV - 1);

  // Elaboration-time parameter sanity check
  if ((CLK_DIV < 4) || ((CLK_DIV % 2) != 0) || (FIFO_DEPTH < 2) ||
      ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_param_check
    $error("uart_rx: CLK_DIV must be even >= 4, FIFO_DEPTH a power of two >= 2");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             sync1;
  logic             rxs;
  logic             push_c;
  logic             pop_c;

  // Two-flop synchronizer; resets to the idle (high) line level
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= rx;
      rxs   <= sync1;
    end
  end

  // Frame decoder: counter reloads land each sample in the middle of a bit
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!rxs) begin
            state <= START;
            cnt   <= HALF_LOAD;
          end
        end
        START: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else if (!rxs) begin
            state   <= DATA;
            cnt     <= BIT_LOAD;
            bit_idx <= '0;
          end else begin
            state <= IDLE;
          end
        end
        DATA: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            shift   <= {rxs, shift[7:1]};
            cnt     <= BIT_LOAD;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end
          end
        end
        STOP: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else if (rxs) begin
            state <= IDLE;
          end else begin
            frame_err <= 1'b1;
            state     <= WAIT_HIGH;
          end
        end
        WAIT_HIGH: begin
          if (rxs) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A good stop bit hands the assembled byte straight to the queue
  assign push_c = (state == STOP) && (cnt == '0) && rxs;
  assign pop_c  = valid && ready;

`ifdef UART_RX_FIFO_EN
  localparam int unsigned ADDR_W = $clog2(FIFO_DEPTH);

  logic [7:0]        mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] rd_next_c;
  logic [ADDR_W:0]   count;
  logic [ADDR_W:0]   count_next_c;
  logic              full_c;
  logic              accept_c;

  assign full_c    = (count == (ADDR_W + 1)'(FIFO_DEPTH));
  assign accept_c  = push_c && (!full_c || pop_c);
  assign rd_next_c = rd_ptr + ADDR_W'(1);

  // Occupancy after this cycle's push/pop
  always_comb begin
    count_next_c = count;
    if (accept_c && !pop_c) begin
      count_next_c = count + (ADDR_W + 1)'(1);
    end else if (pop_c && !accept_c) begin
      count_next_c = count - (ADDR_W + 1)'(1);
    end
  end

  // Storage array, no reset needed: reads are gated by count
  always_ff @(posedge clk) begin
    if (accept_c) begin
      mem[wr_ptr] <= shift;
    end
  end

  // Pointers, flags and a registered copy of the head entry
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      data    <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      overrun <= push_c && full_c && !pop_c;
      count   <= count_next_c;
      valid   <= (count_next_c != '0);
      if (accept_c) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_next_c;
        if (count > (ADDR_W + 1)'(1)) begin
          data <= mem[rd_next_c];
        end else if (accept_c) begin
          data <= shift;
        end
      end else if ((count == '0) && accept_c) begin
        data <= shift;
      end
    end
  end
`else
  // Single holding register with the same handshake and overrun rules
  always_ff @(posedge clk) begin
    if (rst) begin
      data    <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      overrun <= push_c && valid && !pop_c;
      if (push_c && (!valid || pop_c)) begin
        data  <= shift;
        valid <= 1'b1;
      end else if (pop_c) begin
        valid <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx. Frames are driven bit by bit;
// a negedge monitor collects accepted bytes and error pulses, and each
// scenario compares them with the byte list it sent, reduced by the queue
// depth rule (first DEPTH bytes kept while blocked, the rest counted as
// overruns).
`timescale 1ns/1ps

module tb_uart_rx;

  localparam int unsigned CLK_DIV = 16;
`ifdef UART_RX_FIFO_EN
  localparam int unsigned DEPTH = 4;
`else
  localparam int unsigned DEPTH = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       overrun;

  int checks = 0;
  int errors = 0;

  logic [7:0] got[$];
  int         fe_cnt = 0;
  int         ov_cnt = 0;
  logic       prev_hold = 1'b0;
  logic [7:0] prev_data = 8'h00;

  uart_rx #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(4)) dut (
    .clk(clk),
    .rst(rst),
    .rx(rx),
    .data(data),
    .valid(valid),
    .ready(ready),
    .frame_err(frame_err),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Inputs change just after posedge, so at negedge both inputs and outputs
  // show exactly what the next rising edge will act on.
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_hold) begin
        checks++;
        if (!valid || data !== prev_data) begin
          errors++;
          $display("FAIL hold_stable: valid=%0b data=%02h, required valid=1 data=%02h",
                   valid, data, prev_data);
        end
      end
      if (valid && ready) got.push_back(data);
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
      prev_hold = valid && !ready;
      prev_data = data;
    end else begin
      prev_hold = 1'b0;
    end
  end

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic line(input logic v, input int cycles);
    rx = v;
    repeat (cycles) step();
  endtask

  task automatic send_byte(input logic [7:0] b);
    line(1'b0, CLK_DIV);
    for (int i = 0; i < 8; i++) line(b[i], CLK_DIV);
    line(1'b1, CLK_DIV);
  endtask

  task automatic send_list(input logic [7:0] q[$]);
    foreach (q[i]) send_byte(q[i]);
  endtask

  task automatic drain();
    ready = 1'b1;
    repeat (DEPTH + 4) step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx = 1'b1;
    ready = 1'b0;
    repeat (4) step();
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b, required 0", valid); end
    checks++;
    if (data !== 8'h00) begin errors++; $display("FAIL reset_data: got %02h, required 00", data); end
    checks++;
    if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %0b, required 0", frame_err); end
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %0b, required 0", overrun); end
    rst = 1'b0;
    repeat (2 * CLK_DIV) step();
  endtask

  task automatic test_latency();
    int first = -1;
    int high_cnt = 0;
    int g0 = got.size();
    int fe0 = fe_cnt;
    int ov0 = ov_cnt;
    ready = 1'b1;
    fork
      send_byte(8'h55);
      begin
        for (int i = 1; i <= 170; i++) begin
          @(posedge clk);
          #1;
          if (valid) begin
            if (first < 0) first = i;
            high_cnt++;
          end
        end
      end
    join
    step();
    checks++;
    if (first != 155) begin errors++; $display("FAIL latency: valid first high at edge %0d, required 155", first); end
    checks++;
    if (high_cnt != 1) begin errors++; $display("FAIL valid_width: valid high %0d cycles, required 1", high_cnt); end
    checks++;
    if (got.size() - g0 != 1) begin
      errors++; $display("FAIL latency_count: accepted %0d bytes, required 1", got.size() - g0);
    end else begin
      checks++;
      if (got[g0] !== 8'h55) begin errors++; $display("FAIL latency_data: got %02h, required 55", got[g0]); end
    end
    checks++;
    if (fe_cnt != fe0 || ov_cnt != ov0) begin
      errors++; $display("FAIL latency_flags: frame_err %0d overrun %0d pulses, required 0 0", fe_cnt - fe0, ov_cnt - ov0);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] q[$] = '{8'hA3, 8'h0F, 8'hFF};
    int g0 = got.size();
    int ov0 = ov_cnt;
    int kept = (q.size() < DEPTH) ? q.size() : DEPTH;
    ready = 1'b0;
    send_list(q);
    repeat (4) step();
    checks++;
    if (ov_cnt - ov0 != q.size() - kept) begin
      errors++; $display("FAIL b2b_overrun: %0d pulses, required %0d", ov_cnt - ov0, q.size() - kept);
    end
    checks++;
    if (got.size() != g0) begin errors++; $display("FAIL b2b_blocked: %0d accepted, required 0", got.size() - g0); end
    drain();
    checks++;
    if (got.size() - g0 != kept) begin
      errors++; $display("FAIL b2b_count: accepted %0d, required %0d", got.size() - g0, kept);
    end else begin
      for (int i = 0; i < kept; i++) begin
        checks++;
        if (got[g0 + i] !== q[i]) begin errors++; $display("FAIL b2b_data[%0d]: got %02h, required %02h", i, got[g0 + i], q[i]); end
      end
    end
  endtask

  task automatic test_overrun();
    logic [7:0] q[$] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    int g0 = got.size();
    int ov0 = ov_cnt;
    int kept = (q.size() < DEPTH) ? q.size() : DEPTH;
    ready = 1'b0;
    send_list(q);
    repeat (4) step();
    checks++;
    if (ov_cnt - ov0 != q.size() - kept) begin
      errors++; $display("FAIL ovr_pulses: %0d, required %0d", ov_cnt - ov0, q.size() - kept);
    end
    drain();
    checks++;
    if (got.size() - g0 != kept) begin
      errors++; $display("FAIL ovr_count: accepted %0d, required %0d", got.size() - g0, kept);
    end else begin
      for (int i = 0; i < kept; i++) begin
        checks++;
        if (got[g0 + i] !== q[i]) begin errors++; $display("FAIL ovr_data[%0d]: got %02h, required %02h", i, got[g0 + i], q[i]); end
      end
    end
  endtask

  task automatic test_frame_error();
    logic [7:0] b = 8'h3C;
    int g0 = got.size();
    int fe0 = fe_cnt;
    int ov0 = ov_cnt;
    ready = 1'b1;
    line(1'b0, CLK_DIV);
    for (int i = 0; i < 8; i++) line(b[i], CLK_DIV);
    line(1'b0, 3 * CLK_DIV);
    line(1'b1, 2 * CLK_DIV);
    send_byte(8'h81);
    repeat (4) step();
    checks++;
    if (fe_cnt - fe0 != 1) begin errors++; $display("FAIL ferr_pulses: %0d, required 1", fe_cnt - fe0); end
    checks++;
    if (ov_cnt != ov0) begin errors++; $display("FAIL ferr_overrun: %0d pulses, required 0", ov_cnt - ov0); end
    checks++;
    if (got.size() - g0 != 1) begin
      errors++; $display("FAIL ferr_count: accepted %0d, required 1", got.size() - g0);
    end else begin
      checks++;
      if (got[g0] !== 8'h81) begin errors++; $display("FAIL ferr_data: got %02h, required 81", got[g0]); end
    end
  endtask

  task automatic test_glitch();
    int g0 = got.size();
    int fe0 = fe_cnt;
    int ov0 = ov_cnt;
    ready = 1'b1;
    line(1'b0, CLK_DIV / 4);
    line(1'b1, 2 * CLK_DIV);
    checks++;
    if (got.size() != g0 || fe_cnt != fe0 || ov_cnt != ov0) begin
      errors++; $display("FAIL glitch_quiet: bytes %0d ferr %0d ovr %0d, required 0 0 0",
                         got.size() - g0, fe_cnt - fe0, ov_cnt - ov0);
    end
    send_byte(8'hC5);
    repeat (4) step();
    checks++;
    if (got.size() - g0 != 1 || got[got.size() - 1] !== 8'hC5) begin
      errors++; $display("FAIL glitch_recover: accepted %0d last %02h, required 1 c5",
                         got.size() - g0, (got.size() > 0) ? got[got.size() - 1] : 8'h00);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b = 8'h99;
    int g0 = got.size();
    int g1;
    ready = 1'b1;
    line(1'b0, CLK_DIV);
    for (int i = 0; i < 4; i++) line(b[i], CLK_DIV);
    line(b[4], CLK_DIV / 2);
    rst = 1'b1;
    rx = 1'b1;
    repeat (3) step();
    checks++;
    if (valid !== 1'b0 || data !== 8'h00) begin
      errors++; $display("FAIL midrst_state: valid=%0b data=%02h, required 0 00", valid, data);
    end
    rst = 1'b0;
    line(1'b1, 2 * CLK_DIV);
    g1 = got.size();
    checks++;
    if (g1 != g0) begin errors++; $display("FAIL midrst_partial: %0d bytes, required 0", g1 - g0); end
    send_byte(8'h7E);
    repeat (4) step();
    checks++;
    if (got.size() - g1 != 1 || got[got.size() - 1] !== 8'h7E) begin
      errors++; $display("FAIL midrst_after: accepted %0d last %02h, required 1 7e",
                         got.size() - g1, (got.size() > 0) ? got[got.size() - 1] : 8'h00);
    end
  endtask

  task automatic test_random_stream();
    logic [7:0] q[$];
    int g0 = got.size();
    ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      logic [7:0] b = 8'($urandom());
      q.push_back(b);
      send_byte(b);
      line(1'b1, $urandom_range(0, 20));
    end
    repeat (4) step();
    checks++;
    if (got.size() - g0 != q.size()) begin
      errors++; $display("FAIL rand_count: accepted %0d, required %0d", got.size() - g0, q.size());
    end else begin
      for (int i = 0; i < q.size(); i++) begin
        checks++;
        if (got[g0 + i] !== q[i]) begin errors++; $display("FAIL rand_data[%0d]: got %02h, required %02h", i, got[g0 + i], q[i]); end
      end
    end
  endtask

  task automatic test_random_blocked();
    for (int r = 0; r < 3; r++) begin
      logic [7:0] q[$];
      int n = $urandom_range(1, 6);
      int g0 = got.size();
      int ov0 = ov_cnt;
      int kept = (n < DEPTH) ? n : DEPTH;
      for (int k = 0; k < n; k++) q.push_back(8'($urandom()));
      ready = 1'b0;
      send_list(q);
      repeat (4) step();
      checks++;
      if (ov_cnt - ov0 != n - kept) begin
        errors++; $display("FAIL rblk_overrun[%0d]: %0d pulses, required %0d", r, ov_cnt - ov0, n - kept);
      end
      drain();
      checks++;
      if (got.size() - g0 != kept) begin
        errors++; $display("FAIL rblk_count[%0d]: accepted %0d, required %0d", r, got.size() - g0, kept);
      end else begin
        for (int i = 0; i < kept; i++) begin
          checks++;
          if (got[g0 + i] !== q[i]) begin errors++; $display("FAIL rblk_data[%0d][%0d]: got %02h, required %02h", r, i, got[g0 + i], q[i]); end
        end
      end
    end
  endtask

  initial begin
    step();
    test_reset();
    test_latency();
    test_back_to_back();
    test_overrun();
    test_frame_error();
    test_glitch();
    test_reset_mid_frame();
    test_random_stream();
    test_random_blocked();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
